// File: rtl/uart_pkg.sv
// Shared UART constants: bit timing, payload width and transmit FSM encoding.
// The receive path imports the same package so both directions agree on timing.
package uart_pkg;
  localparam int CLKS_PER_BIT = 434;
  localparam int DATA_W       = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-side enqueue port of the UART transmitter: byte, strobe and FIFO flags.
interface uart_tx_fifo_if #(parameter int DATA_W = uart_pkg::DATA_W);
  logic [DATA_W-1:0] data_i;
  logic              wr_en_i;
  logic              full_o;
  logic              empty_o;
  logic              overflow_o;

  modport master (output data_i, wr_en_i, input full_o, empty_o, overflow_o);
  modport slave  (input data_i, wr_en_i, output full_o, empty_o, overflow_o);
endinterface

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO with registered full/empty and a drop-on-full
// overflow pulse; head entry is readable combinationally on rd_data.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              overflow
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q, ovf_q;
  logic              wr_ok, rd_ok;

  assign wr_ok = wr_en & ~full_q;
  assign rd_ok = rd_en & ~empty_q;

  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (ADDR_W+1)'(DEPTH));
      empty_q <= (count_d == '0);
      ovf_q   <= wr_en & full_q;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the count.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = ovf_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter: host bytes queue in a sync_fifo and are serialized 8N1,
// LSB first, with a registered line output and one idle cycle between frames.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int DATA_W       = uart_pkg::DATA_W,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_fifo_if.slave   host,
  output logic            tx_serial,
  output logic            tx_busy_o,
  output logic            tx_done_o
);
  import uart_pkg::*;

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [IDX_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              rd_en, baud_last;
  logic [DATA_W-1:0] head;

  sync_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (host.wr_en_i),
    .wr_data  (host.data_i),
    .rd_en    (rd_en),
    .rd_data  (head),
    .full     (host.full_o),
    .empty    (host.empty_o),
    .overflow (host.overflow_o)
  );

  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT-1));

  // tx_d is the level for the cycle after this edge, so the line is a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    rd_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!host.empty_o) begin
          rd_en   = 1'b1;
          shift_d = head;
          bit_d   = '0;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: if (baud_last) begin
        state_d = ST_DATA;
        baud_d  = '0;
        tx_d    = shift_q[0];
      end
      ST_DATA: if (baud_last) begin
        baud_d = '0;
        if (bit_q == IDX_W'(DATA_W-1)) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          tx_d    = shift_q[1];
        end
      end
      default: if (baud_last) begin
        state_d = ST_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_serial = tx_q;
  assign tx_busy_o = (state_q != ST_IDLE);
  assign tx_done_o = (state_q == ST_STOP) && baud_last;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line decoder turns tx_serial back into frames,
// directed and random writes are checked against a queue of expected bytes.
module tb_uart_tx_fifo;
  localparam int CPB   = 20;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_serial, tx_busy, tx_done;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (bus),
    .tx_serial (tx_serial),
    .tx_busy_o (tx_busy),
    .tx_done_o (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       sbit;
    logic       pbit;
    logic       stable;
    int         done_at;
    int         start_cyc;
  } frame_t;

  frame_t mon_q[$];
  int     done_cnt = 0;
  int     mon_frames = 0;
  int     aborted = 0;

  // Line decoder: one frame is FRAME cycles starting at the first low sample;
  // each bit must hold its level for its whole period with busy asserted.
  initial begin
    bit     in_frame;
    int     mk;
    logic   lvl [10];
    frame_t f;
    in_frame = 0;
    mk = 0;
    f = '{default: 0};
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) done_cnt++;
      if (rst) begin
        if (in_frame) aborted++;
        in_frame = 0;
      end else begin
        if (!in_frame && tx_serial === 1'b0) begin
          in_frame = 1;
          mk = 0;
          f.stable = 1'b1;
          f.done_at = -1;
          f.start_cyc = cyc;
        end
        if (in_frame) begin
          if (mk % CPB == 0) lvl[mk / CPB] = tx_serial;
          else if (tx_serial !== lvl[mk / CPB]) f.stable = 1'b0;
          if (tx_busy !== 1'b1) f.stable = 1'b0;
          if (tx_done === 1'b1) f.done_at = mk;
          if (mk == FRAME - 1) begin
            f.sbit = lvl[0];
            for (int i = 0; i < 8; i++) f.data[i] = lvl[i+1];
            f.pbit = lvl[9];
            mon_q.push_back(f);
            mon_frames++;
            in_frame = 0;
          end else mk++;
        end
      end
    end
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: observed no finish, required finish within budget");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    bus.data_i  = b;
    bus.wr_en_i = 1'b1;
    step();
    bus.wr_en_i = 1'b0;
  endtask

  // Waits for the next decoded frame while scrambling data_i to prove latching.
  task automatic wait_frame(input logic [7:0] exp, input string tag, output int sc);
    int     n;
    frame_t f;
    n = 0;
    sc = -1;
    while (mon_q.size() == 0 && n < 3 * FRAME) begin
      bus.data_i = 8'($urandom);
      step();
      n++;
    end
    if (mon_q.size() == 0) begin
      chk({tag, " timeout"}, 32'd0, 32'd1);
    end else begin
      f = mon_q.pop_front();
      chk({tag, " data"}, 32'(f.data), 32'(exp));
      chk({tag, " start"}, 32'(f.sbit), 32'd0);
      chk({tag, " stop"}, 32'(f.pbit), 32'd1);
      chk({tag, " stable"}, 32'(f.stable), 32'd1);
      chk({tag, " done_at"}, 32'(f.done_at), 32'(FRAME - 1));
      sc = f.start_cyc;
    end
  endtask

  initial begin
    int         low_cnt, s0, s1, s2, d0;
    logic [7:0] exp_q[$];
    logic [7:0] b;

    bus.data_i  = '0;
    bus.wr_en_i = 1'b0;

    // Reset and a long idle line.
    repeat (5) step();
    chk("rst tx", 32'(tx_serial), 32'd1);
    chk("rst empty", 32'(bus.empty_o), 32'd1);
    chk("rst full", 32'(bus.full_o), 32'd0);
    chk("rst ovf", 32'(bus.overflow_o), 32'd0);
    chk("rst busy", 32'(tx_busy), 32'd0);
    chk("rst done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      step();
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) low_cnt++;
    end
    chk("idle line", 32'(low_cnt), 32'd0);
    chk("idle done cnt", 32'(done_cnt), 32'd0);

    // Single byte: pop one edge after the write, line falls on the pop edge.
    wr(8'hF2);
    chk("lat empty", 32'(bus.empty_o), 32'd0);
    chk("lat tx high", 32'(tx_serial), 32'd1);
    step();
    chk("lat tx low", 32'(tx_serial), 32'd0);
    chk("lat busy", 32'(tx_busy), 32'd1);
    chk("pop empty", 32'(bus.empty_o), 32'd1);
    wait_frame(8'hF2, "single", s0);
    step();
    chk("single done cnt", 32'(done_cnt), 32'd1);
    chk("single idle busy", 32'(tx_busy), 32'd0);

    // Back-to-back frames: start-to-start is ten bits plus one idle cycle.
    bus.wr_en_i = 1'b1;
    bus.data_i = 8'h55; step();
    bus.data_i = 8'hAA; step();
    bus.data_i = 8'h00; step();
    bus.wr_en_i = 1'b0;
    wait_frame(8'h55, "b2b0", s0);
    wait_frame(8'hAA, "b2b1", s1);
    wait_frame(8'h00, "b2b2", s2);
    chk("b2b gap1", 32'(s1 - s0), 32'(FRAME + 1));
    chk("b2b gap2", 32'(s2 - s1), 32'(FRAME + 1));
    repeat (3) step();

    // Fill to full: byte 1 leaves on the second edge, so write 17 fills it.
    bus.wr_en_i = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      bus.data_i = 8'(i);
      step();
      if (i == 16) chk("fill full@16", 32'(bus.full_o), 32'd0);
      if (i == 17) begin
        chk("fill full@17", 32'(bus.full_o), 32'd1);
        chk("fill ovf@17", 32'(bus.overflow_o), 32'd0);
      end
      if (i == 18) begin
        chk("fill ovf@18", 32'(bus.overflow_o), 32'd1);
        chk("fill full@18", 32'(bus.full_o), 32'd1);
      end
    end
    bus.wr_en_i = 1'b0;
    step();
    chk("ovf pulse end", 32'(bus.overflow_o), 32'd0);
    wait_frame(8'h01, "fill f1", s0);
    step();
    chk("full before pop", 32'(bus.full_o), 32'd1);
    step();
    chk("full after pop", 32'(bus.full_o), 32'd0);
    for (int i = 2; i <= 17; i++) wait_frame(8'(i), $sformatf("fill f%0d", i), s1);
    repeat (3 * FRAME) step();
    chk("fill no 0x12", 32'(mon_q.size()), 32'd0);
    chk("fill empty", 32'(bus.empty_o), 32'd1);

    // Reset during data bit 4 abandons the frame and the queued bytes.
    wr(8'hF2);
    step();
    chk("mid tx low", 32'(tx_serial), 32'd0);
    wr(8'h11);
    wr(8'h22);
    repeat (5 * CPB + CPB / 2 - 2) step();
    chk("mid bit4", 32'(tx_serial), 32'd1);
    chk("mid busy", 32'(tx_busy), 32'd1);
    d0 = done_cnt;
    rst = 1'b1;
    step();
    chk("mid rst tx", 32'(tx_serial), 32'd1);
    chk("mid rst empty", 32'(bus.empty_o), 32'd1);
    chk("mid rst busy", 32'(tx_busy), 32'd0);
    rst = 1'b0;
    step();
    chk("mid aborted", 32'(aborted), 32'd1);
    chk("mid no done", 32'(done_cnt), 32'(d0));
    wr(8'h3C);
    wait_frame(8'h3C, "after rst", s0);
    repeat (3 * FRAME) step();
    chk("after rst drained", 32'(mon_q.size()), 32'd0);

    // Random bursts with random gaps; the decoded line is the loopback receiver.
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(2, 6);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        wr(b);
        repeat ($urandom_range(0, 2)) begin
          bus.data_i = 8'($urandom);
          step();
        end
      end
      while (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        wait_frame(b, $sformatf("rand r%0d", r), s0);
      end
    end

    repeat (3) step();
    chk("done pulses", 32'(done_cnt), 32'(mon_frames));
    chk("end empty", 32'(bus.empty_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
